// File: rtl/inv_mix_columns_seq.sv
// Column-serial (Inv)MixColumns stage for the AES round datapath.
// Processes COLS_PER_CYCLE columns per clock behind a valid/ready handshake.
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dout,
  output logic         busy
);

  localparam int unsigned NCYC = 4 / COLS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state, state_nxt;
  logic [1:0]   grp, grp_nxt;
  logic [127:0] st_q;
  logic [127:0] dout_q, dout_nxt;
  logic         inv_q;
  logic         accept;
  logic         last_grp;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

  // Products built from x2/x4/x8 terms: 3=2^1, 9=8^1, b=8^2^1, d=8^4^1, e=8^4^2.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv_m);
    logic [7:0]  m1 [4];
    logic [7:0]  m2 [4];
    logic [7:0]  m4 [4];
    logic [7:0]  m8 [4];
    logic [31:0] r;
    int unsigned j1, j2, j3;
    r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m1[i] = a[31-8*i -: 8];
      m2[i] = xtime(m1[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      j1 = (i + 1) % 4;
      j2 = (i + 2) % 4;
      j3 = (i + 3) % 4;
      if (!inv_m)
        r[31-8*i -: 8] = m2[i] ^ (m2[j1] ^ m1[j1]) ^ m1[j2] ^ m1[j3];
      else
        r[31-8*i -: 8] = (m8[i]  ^ m4[i]  ^ m2[i])
                       ^ (m8[j1] ^ m2[j1] ^ m1[j1])
                       ^ (m8[j2] ^ m4[j2] ^ m1[j2])
                       ^ (m8[j3] ^ m1[j3]);
    end
    return r;
  endfunction

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept    = in_ready & in_valid;
  assign last_grp  = (grp == 2'(NCYC - 1));
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign dout      = dout_q;

  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = BUSY;
          grp_nxt   = '0;
        end
      end
      BUSY: begin
        grp_nxt = last_grp ? '0 : grp + 2'd1;
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        grp_nxt = '0;
        if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        grp_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    int unsigned col;
    dout_nxt = dout_q;
    for (int unsigned g = 0; g < COLS_PER_CYCLE; g++) begin
      col = int'(grp) * COLS_PER_CYCLE + g;
      dout_nxt[127-32*col -: 32] = mix_col(st_q[127-32*col -: 32], inv_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grp   <= '0;
    end else begin
      state <= state_nxt;
      grp   <= grp_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      inv_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      if (accept) begin
        st_q  <= din;
        inv_q <= inv;
      end
      if (state == BUSY) dout_q <= dout_nxt;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         iv   [3];
  logic         inr  [3];
  logic         inv_s[3];
  logic [127:0] din_s[3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] dout_w[3];
  logic         busy_w[3];

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V_MIX   = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_COLIN = 128'hd4d4d4d5_01010101_c6c6c6c6_f20a225c;
  localparam logic [127:0] V_COLMX = 128'hd5d5d7d6_01010101_c6c6c6c6_9fdc589d;
  localparam int NCYC [3] = '{4, 2, 1};

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(inr[0]), .inv(inv_s[0]),
    .din(din_s[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .dout(dout_w[0]), .busy(busy_w[0]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(inr[1]), .inv(inv_s[1]),
    .din(din_s[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .dout(dout_w[1]), .busy(busy_w[1]));
  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(inr[2]), .inv(inv_s[2]),
    .din(din_s[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .dout(dout_w[2]), .busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Counts clock edges (observed at negedges) until out_valid, bounded.
  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input int k, input string tag, input logic [127:0] d,
                         input logic iinv, input logic [127:0] exp);
    int lat;
    check({tag, "_in_ready"}, 128'(inr[k]), 128'(1));
    iv[k] = 1'b1; din_s[k] = d; inv_s[k] = iinv;
    @(negedge clk);
    iv[k] = 1'b0; din_s[k] = '0; inv_s[k] = ~iinv;
    wait_out(k, lat);
    check({tag, "_lat"}, 128'(lat), 128'(NCYC[k]));
    check({tag, "_dout"}, dout_w[k], exp);
    @(negedge clk);
    check({tag, "_drain"}, 128'(ov[k]), 128'(0));
  endtask

  initial begin
    int lat;
    logic [127:0] r, mid;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; inv_s[k] = 1'b0; din_s[k] = '0; ordy[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(ov[0]), 128'(0));
    check("rst_dout", dout_w[0], '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(inr[0]), 128'(1));
    check("rst_busy", 128'(busy_w[0]), 128'(0));

    // Forward and inverse, plus a column-position vector.
    run_vec(0, "fwd", V_PLAIN, 1'b0, V_MIX);
    run_vec(0, "inv", V_MIX, 1'b1, V_PLAIN);
    run_vec(0, "col", V_COLIN, 1'b0, V_COLMX);

    // Backpressure in DONE.
    ordy[0] = 1'b0;
    iv[0] = 1'b1; din_s[0] = V_PLAIN; inv_s[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    wait_out(0, lat);
    check("bp_lat", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1; din_s[0] = V_COLIN; inv_s[0] = 1'b1;
      check("bp_in_ready", 128'(inr[0]), 128'(0));
      @(negedge clk);
      check("bp_valid", 128'(ov[0]), 128'(1));
      check("bp_dout", dout_w[0], V_MIX);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 128'(ov[0]), 128'(0));
    check("bp_release_idle", 128'(inr[0]), 128'(1));
    check("bp_release_busy", 128'(busy_w[0]), 128'(0));

    // Back-to-back with inv toggled.
    iv[0] = 1'b1; din_s[0] = V_PLAIN; inv_s[0] = 1'b0;
    @(negedge clk);
    din_s[0] = V_MIX; inv_s[0] = 1'b1;
    wait_out(0, lat);
    check("b2b_lat0", 128'(lat), 128'(4));
    check("b2b_dout0", dout_w[0], V_MIX);
    check("b2b_ready_in_done", 128'(inr[0]), 128'(1));
    @(negedge clk);
    iv[0] = 1'b0; din_s[0] = '0;
    check("b2b_busy", 128'(busy_w[0]), 128'(1));
    wait_out(0, lat);
    check("b2b_lat1", 128'(lat), 128'(4));
    check("b2b_dout1", dout_w[0], V_PLAIN);
    @(negedge clk);
    check("b2b_drain", 128'(ov[0]), 128'(0));

    // Reset mid-BUSY at group counter 2.
    iv[0] = 1'b1; din_s[0] = V_PLAIN; inv_s[0] = 1'b0;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(ov[0]), 128'(0));
    check("mid_rst_dout", dout_w[0], '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 128'(inr[0]), 128'(1));
    check("mid_rst_busy", 128'(busy_w[0]), 128'(0));
    run_vec(0, "post_rst", V_MIX, 1'b1, V_PLAIN);

    // Wider configurations.
    for (int k = 1; k < 3; k++) begin
      run_vec(k, $sformatf("w%0d_fwd", k), V_PLAIN, 1'b0, V_MIX);
      run_vec(k, $sformatf("w%0d_inv", k), V_MIX, 1'b1, V_PLAIN);
      run_vec(k, $sformatf("w%0d_col", k), V_COLIN, 1'b0, V_COLMX);
    end

    // Random forward/inverse round trips on every configuration.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 200; n++) begin
        r = {$urandom, $urandom, $urandom, $urandom};
        iv[k] = 1'b1; din_s[k] = r; inv_s[k] = 1'b0;
        @(negedge clk);
        iv[k] = 1'b0;
        wait_out(k, lat);
        mid = dout_w[k];
        @(negedge clk);
        iv[k] = 1'b1; din_s[k] = mid; inv_s[k] = 1'b1;
        @(negedge clk);
        iv[k] = 1'b0;
        wait_out(k, lat);
        check($sformatf("rt%0d_%0d", k, n), dout_w[k], r);
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
